// File: rtl/add_driver_pkg.sv
// add_driver_pkg: shared constants for the add_driver vector-add engine.
//   DATA_W        - width of every data word and of the command bus fields
//   OP_*          - command opcodes carried on the opcode bus
//   BUF_*         - buffer select values carried on the id bus
package add_driver_pkg;

   localparam int unsigned DATA_W = 32;

   localparam logic [DATA_W-1:0] OP_NOP   = 32'd0;
   localparam logic [DATA_W-1:0] OP_WRITE = 32'd1;
   localparam logic [DATA_W-1:0] OP_ADD   = 32'd2;
   localparam logic [DATA_W-1:0] OP_READ  = 32'd3;

   localparam logic [DATA_W-1:0] BUF_A = 32'd1;
   localparam logic [DATA_W-1:0] BUF_B = 32'd2;
   localparam logic [DATA_W-1:0] BUF_C = 32'd3;

endpackage

// File: rtl/vec_buffer.sv
// vec_buffer: DEPTH x DATA_W register file.
//   i_clock - clock, all updates on the rising edge
//   i_reset - synchronous active-high clear of every word
//   i_we    - write enable for word i_addr
//   i_addr  - word address shared by the write and read ports
//   i_wdata - write data
//   o_rdata - asynchronous read of word i_addr (pre-edge value)
module vec_buffer
   import add_driver_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_we,
   input  logic [AW-1:0]     i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/add_driver.sv
// add_driver: one-command-per-cycle vector-add engine over three buffers A, B, C.
//   clock  - single clock
//   reset  - synchronous active-high; clears all buffers and out
//   opcode - 0 NOP, 1 WRITE, 2 ADD, 3 READ; anything else behaves as NOP
//   id     - buffer select 1=A, 2=B, 3=C; other values write nothing, read 0
//   in     - write data for WRITE
//   addr   - word address, only the low AW bits are used
//   out    - registered result (write echo, sum, or read data)
module add_driver
   import add_driver_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] opcode,
   input  logic [DATA_W-1:0] id,
   input  logic [DATA_W-1:0] in,
   input  logic [DATA_W-1:0] addr,
   output logic [DATA_W-1:0] out
);

   logic [AW-1:0]     w_a;
   logic [DATA_W-1:0] w_rd_a;
   logic [DATA_W-1:0] w_rd_b;
   logic [DATA_W-1:0] w_rd_c;
   logic [DATA_W-1:0] w_rd_sel;
   logic [DATA_W-1:0] w_sum;
   logic [DATA_W-1:0] w_wdata;
   logic              w_is_write;
   logic              w_is_add;
   logic              w_we_a;
   logic              w_we_b;
   logic              w_we_c;
   logic              w_unused_addr;
   logic [DATA_W-1:0] r_out;

   // Upper address bits are ignored so addresses wrap modulo DEPTH.
   assign w_a           = addr[AW-1:0];
   assign w_unused_addr = ^addr[DATA_W-1:AW];

   assign w_is_write = (opcode == OP_WRITE);
   assign w_is_add   = (opcode == OP_ADD);

   // Operands are the pre-edge buffer values, so in-place accumulate is safe.
   assign w_sum   = w_rd_a + w_rd_b;
   assign w_wdata = w_is_write ? in : w_sum;

   assign w_we_a = (w_is_write || w_is_add) && (id == BUF_A);
   assign w_we_b = (w_is_write || w_is_add) && (id == BUF_B);
   assign w_we_c = (w_is_write || w_is_add) && (id == BUF_C);

   always_comb begin
      w_rd_sel = '0;
      if (id == BUF_A) begin
         w_rd_sel = w_rd_a;
      end else if (id == BUF_B) begin
         w_rd_sel = w_rd_b;
      end else if (id == BUF_C) begin
         w_rd_sel = w_rd_c;
      end
   end

   vec_buffer #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_buf_a (
      .i_clock (clock),
      .i_reset (reset),
      .i_we    (w_we_a),
      .i_addr  (w_a),
      .i_wdata (w_wdata),
      .o_rdata (w_rd_a)
   );

   vec_buffer #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_buf_b (
      .i_clock (clock),
      .i_reset (reset),
      .i_we    (w_we_b),
      .i_addr  (w_a),
      .i_wdata (w_wdata),
      .o_rdata (w_rd_b)
   );

   vec_buffer #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_buf_c (
      .i_clock (clock),
      .i_reset (reset),
      .i_we    (w_we_c),
      .i_addr  (w_a),
      .i_wdata (w_wdata),
      .o_rdata (w_rd_c)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_out <= '0;
      end else begin
         // Invalid ids still echo/sum on WRITE/ADD; READ of them yields 0.
         case (opcode)
            OP_WRITE: r_out <= in;
            OP_ADD:   r_out <= w_sum;
            OP_READ:  r_out <= w_rd_sel;
            default:  r_out <= r_out;
         endcase
      end
   end

   assign out = r_out;

endmodule

// File: tb/tb_add_driver.sv
module tb_add_driver;
   import add_driver_pkg::*;

   localparam int unsigned DEPTH = 16;

   logic              clock;
   logic              reset;
   logic [DATA_W-1:0] opcode;
   logic [DATA_W-1:0] id;
   logic [DATA_W-1:0] in;
   logic [DATA_W-1:0] addr;
   logic [DATA_W-1:0] out;

   int n_tests;
   int n_fail;

   add_driver #(
      .DEPTH (DEPTH)
   ) dut (
      .clock  (clock),
      .reset  (reset),
      .opcode (opcode),
      .id     (id),
      .in     (in),
      .addr   (addr),
      .out    (out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Apply one command for one edge, then sample out 1 time unit later.
   task automatic cmd(input logic [31:0] op, input logic [31:0] i_id,
                      input logic [31:0] a, input logic [31:0] d);
      opcode = op;
      id     = i_id;
      addr   = a;
      in     = d;
      @(posedge clock);
      #1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      opcode  = OP_NOP;
      id      = '0;
      in      = '0;
      addr    = '0;
      reset   = 1'b1;
      #1;
      repeat (2) @(posedge clock);
      #1;
      check("reset_out", out, 32'd0);
      reset = 1'b0;

      cmd(OP_READ, 1, 0, 0);  check("rst_read_a", out, 32'd0);
      cmd(OP_READ, 2, 0, 0);  check("rst_read_b", out, 32'd0);
      cmd(OP_READ, 3, 0, 0);  check("rst_read_c", out, 32'd0);

      cmd(OP_WRITE, 1, 0, 5); check("wr_a0_echo", out, 32'd5);
      cmd(OP_WRITE, 2, 0, 6); check("wr_b0_echo", out, 32'd6);
      for (int k = 0; k < 3; k++) begin
         cmd(OP_ADD, 3, 0, 0); check("add_c0_held", out, 32'd11);
      end
      cmd(OP_READ, 3, 0, 0);  check("read_c0", out, 32'd11);

      cmd(OP_WRITE, 1, 3, 32'hFFFF_FFFF); check("wr_a3_echo", out, 32'hFFFF_FFFF);
      cmd(OP_WRITE, 2, 3, 2);             check("wr_b3_echo", out, 32'd2);
      cmd(OP_ADD, 3, 3, 0);               check("add_wrap", out, 32'd1);
      cmd(OP_READ, 3, 3, 0);              check("read_c3", out, 32'd1);

      cmd(OP_WRITE, 1, DEPTH + 2, 7); check("wr_addr_wrap", out, 32'd7);
      cmd(OP_READ, 1, 2, 0);          check("read_addr_wrap", out, 32'd7);
      cmd(OP_READ, 1, 32'hABCD_0002, 0); check("read_high_bits", out, 32'd7);

      cmd(OP_WRITE, 0, 0, 9);  check("wr_id0_echo", out, 32'd9);
      cmd(OP_READ, 5, 0, 0);   check("read_id5", out, 32'd0);
      cmd(OP_ADD, 4, 0, 0);    check("add_id4_out", out, 32'd11);
      cmd(OP_READ, 1, 0, 0);   check("a0_untouched", out, 32'd5);
      cmd(OP_READ, 2, 0, 0);   check("b0_untouched", out, 32'd6);
      cmd(OP_READ, 3, 0, 0);   check("c0_untouched", out, 32'd11);

      cmd(OP_NOP, 1, 0, 99);   check("nop_hold", out, 32'd11);
      cmd(32'd7, 1, 0, 99);    check("op7_hold", out, 32'd11);
      cmd(OP_READ, 1, 0, 0);   check("op7_no_write", out, 32'd5);

      cmd(OP_WRITE, 1, 0, 1);  check("wr_a0_1", out, 32'd1);
      cmd(OP_WRITE, 2, 0, 1);  check("wr_b0_1", out, 32'd1);
      for (int k = 0; k < 3; k++) begin
         cmd(OP_ADD, 1, 0, 0); check("accum_a0", out, 32'(2 + k));
      end
      cmd(OP_READ, 1, 0, 0);   check("read_accum", out, 32'd4);

      // Reset with a live WRITE on the bus: command dropped, state cleared.
      reset = 1'b1;
      cmd(OP_WRITE, 1, 0, 55); check("mid_reset_out", out, 32'd0);
      reset = 1'b0;
      cmd(OP_READ, 1, 0, 0);   check("post_rst_a0", out, 32'd0);
      cmd(OP_READ, 3, 3, 0);   check("post_rst_c3", out, 32'd0);
      cmd(OP_READ, 1, 2, 0);   check("post_rst_a2", out, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
